// File: rtl/seg7_pkg.sv
// Shared types and constants for the multiplexed 7-segment scanner.
package seg7_pkg;

  // All segments off (active-low outputs).
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // One digit slot: enable flag plus hex nibble.
  typedef struct packed {
    logic       en;
    logic [3:0] val;
  } digit_t;

  // Width of an index that addresses n items.
  function automatic int idx_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/bcd7seg.sv
// Hex nibble to active-low 7-segment pattern, ordered {g,f,e,d,c,b,a}.
module bcd7seg (
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  // Combinational lookup of the glyph for each hex value.
  always_comb begin
    seg = 7'h7F;
    case (hex)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
  end

endmodule

// File: rtl/seg7_div_ctr.sv
// Slot timing: divides clk into digit slots and steps the slot index,
// flagging the frame boundary where the slot index wraps back to 0.
module seg7_div_ctr
  import seg7_pkg::*;
#(
  parameter  int NDIGITS = 8,
  parameter  int CLK_DIV = 1000,
  localparam int IDXW    = idx_w(NDIGITS),
  localparam int DIVW    = idx_w(CLK_DIV)
) (
  input  logic            clk,
  input  logic            rst,
  output logic [DIVW-1:0] div_cnt,
  output logic [IDXW-1:0] slot,
  output logic            wrap,
  output logic            frame_tick
);

  logic slot_end;

  // Last cycle of a slot, and last cycle of the whole frame.
  always_comb begin
    slot_end = (div_cnt == DIVW'(CLK_DIV - 1));
    wrap     = slot_end && (slot == IDXW'(NDIGITS - 1));
  end

  // Divider and slot counters; frame_tick is the registered wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt    <= '0;
      slot       <= '0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= wrap;
      if (slot_end) begin
        div_cnt <= '0;
        slot    <= wrap ? '0 : slot + 1'b1;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed common-anode 7-segment scanner. The host fills a shadow
// bank; a commit copies it into the display bank only at a frame boundary
// so the panel never shows a half-written update.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter  int NDIGITS   = 8,
  parameter  int CLK_DIV   = 1000,
  parameter  int BLANK_CYC = 2,
  localparam int IDXW      = idx_w(NDIGITS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [IDXW-1:0]    wr_idx,
  input  logic [3:0]         wr_val,
  input  logic               clr,
  input  logic               commit,
  input  logic               lzb,
  output logic               commit_pend,
  output logic               frame_tick,
  output logic [NDIGITS-1:0] an,
  output logic [6:0]         seg
);

  localparam int DIVW = idx_w(CLK_DIV);

  logic [DIVW-1:0]    div_cnt;
  logic [IDXW-1:0]    slot;
  logic               wrap;
  digit_t             sh_bank [NDIGITS];
  digit_t             dp_bank [NDIGITS];
  logic [NDIGITS-1:0] blank;
  logic               all_zero;
  logic [3:0]         cur_val;
  logic [6:0]         dec_seg;

  seg7_div_ctr #(
    .NDIGITS (NDIGITS),
    .CLK_DIV (CLK_DIV)
  ) u_div (
    .clk        (clk),
    .rst        (rst),
    .div_cnt    (div_cnt),
    .slot       (slot),
    .wrap       (wrap),
    .frame_tick (frame_tick)
  );

  // Shadow bank: clr drops every enable, then a same-cycle write re-enables its digit.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NDIGITS; i++) begin
        sh_bank[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NDIGITS; i++) begin
        if (clr) begin
          sh_bank[i].en <= 1'b0;
        end
        if (wr_en && (wr_idx == IDXW'(i))) begin
          sh_bank[i].en  <= 1'b1;
          sh_bank[i].val <= wr_val;
        end
      end
    end
  end

  // Commit handshake: the frame boundary consumes a pending commit and copies the pre-edge shadow.
  always_ff @(posedge clk) begin
    if (rst) begin
      commit_pend <= 1'b0;
      for (int i = 0; i < NDIGITS; i++) begin
        dp_bank[i] <= '0;
      end
    end else if (wrap && commit_pend) begin
      commit_pend <= 1'b0;
      for (int i = 0; i < NDIGITS; i++) begin
        dp_bank[i] <= sh_bank[i];
      end
    end else if (commit) begin
      commit_pend <= 1'b1;
    end
  end

  // Per-digit blanking: disabled digits, plus leading zeros above digit 0 when lzb is set.
  always_comb begin
    blank    = '0;
    all_zero = 1'b1;
    for (int d = NDIGITS - 1; d >= 0; d--) begin
      if (dp_bank[d].en && (dp_bank[d].val != 4'h0)) begin
        all_zero = 1'b0;
      end
      blank[d] = !dp_bank[d].en || (lzb && (d > 0) && all_zero);
    end
  end

  assign cur_val = dp_bank[slot].val;

  bcd7seg u_dec (
    .hex (cur_val),
    .seg (dec_seg)
  );

  // Registered drivers: anodes stay off during the ghost-suppression window of each slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      an  <= '1;
      seg <= SEG_BLANK;
    end else if ((div_cnt < DIVW'(BLANK_CYC)) || blank[slot]) begin
      an  <= '1;
      seg <= SEG_BLANK;
    end else begin
      an  <= ~(NDIGITS'(1) << slot);
      seg <= dec_seg;
    end
  end

endmodule
